mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage load/store unit of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns the M-stage ALU result (address) and store operand into a request/grant/response transaction on the data-memory bus.
- Aligns and sign/zero-extends load data into `ld_dataM`.
- Holds the pipeline through `o_stallM` while an access is outstanding.

## Interface
- `ADDR_W`, 32: width of `o_mem_addr`, taken from `alu_dataM[ADDR_W-1:0]`.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous reset, active-high.
- `i_validM`  in  1  M-stage holds a real instruction.
- `i_flushM`  in  1  M-stage instruction is squashed.
- `i_mem_rdM`, `i_mem_wrM`  in  1 each  load / store instruction.
- `i_funct3M`  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores use 000/001/010.
- `i_alu_dataM`  in  32  effective address.
- `i_rs2_dataM`  in  32  store operand.
- `o_mem_req`  out  1  bus request.
- `o_mem_we`  out  1  write.
- `o_mem_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `o_mem_be`  out  4  byte enables.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `i_mem_gnt`  in  1  request accepted.
- `i_mem_rvalid`  in  1  response (read data or write ack).
- `i_mem_rdata`  in  32  read word.
- `o_ld_dataM`  out  32  extended load result to MEM/WB.
- `o_stallM`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; stall MEM/WB.
- `o_access_fault`  out  1  one-cycle pulse: misaligned address or illegal funct3.

## Operation
- FSM states: IDLE, REQ, RESP. Reset → IDLE.
- Outputs during reset:
  - `o_mem_req`=0, `o_mem_we`=0, `o_mem_be`=0.
  - `o_mem_addr`=0, `o_mem_wdata`=0.
  - `o_ld_dataM`=0, `o_stallM`=0, `o_access_fault`=0.
- Access start condition: `i_validM & ~i_flushM & (i_mem_rdM | i_mem_wrM)`.
- Fault check:
  - Faults: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0; funct3 011/110/111; stores with funct3 1xx.
  - On fault: no request, `o_access_fault`=1 for that cycle, `o_ld_dataM`=0, no stall, stay IDLE.
- IDLE with a legal access:
  - `o_mem_req`=1 combinationally; address, we, be, wdata are registered into a request latch on the same edge.
  - `o_stallM`=1.
  - `i_mem_gnt`=1 → RESP; else → REQ.
- REQ: `o_mem_req` held with latched fields, `o_stallM`=1.
  - `i_mem_gnt` → RESP.
  - `i_flushM` before grant → drop request, go to IDLE.
- RESP: `o_mem_req`=0. Flush is ignored here: a granted access always completes.
  - Without `i_mem_rvalid`: `o_stallM`=1.
  - With `i_mem_rvalid`: `o_stallM`=0, `o_ld_dataM` is driven from `i_mem_rdata` that cycle, go to IDLE.
- Store lanes:
  - sb: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - sw: wdata=rs2, be=4'hF.
- Load extraction uses the latched addr[1:0] and funct3. The selected byte/half is sign- or zero-extended to 32 bits.
- Loads set `o_mem_be` as for stores of the same size.
- `i_mem_rdata` is ignored on store responses; `o_ld_dataM`=0.
- Non-memory instructions: `o_ld_dataM`=0, `o_stallM`=0.

## Timing
- Minimum access: gnt in cycle 0, rvalid in cycle 1.
  - `o_stallM`=1 in cycle 0 only.
  - `o_ld_dataM` valid in cycle 1, captured by MEM/WB at the end of cycle 1.
- Each cycle of delayed gnt or rvalid adds one stall cycle.
- `o_stallM` deasserts combinationally in the rvalid cycle.
- A new access can issue in the cycle after rvalid, giving back-to-back throughput of one access per 2 cycles.
- At most one outstanding transaction.
- `i_mem_rvalid` in IDLE/REQ is a protocol error: ignore it, no state change.
- Async reset mid-transaction returns to IDLE immediately; the bus slave must be reset by the same `i_rst`.

## Structure
- Shared package `rv_mem_pkg`:
  - funct3 load/store encodings.
  - `mem_state_e` enum.
  - `be_t` (4-bit) typedef.
- One sub-module, `load_extend`: combinational addr[1:0] + funct3 + rdata → 32-bit result. It is reusable by the future D-cache fill path.

## Test plan
- lw addr 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF → one stall cycle; `o_ld_dataM`=0xDEADBEEF in the rvalid cycle.
- lb addr 0x103, rdata 0x80112233 → `o_ld_dataM`=0xFFFFFF80. Same case as lbu → 0x00000080.
- sh addr 0x202, rs2 0x0000ABCD → be=4'b1100, wdata=0xABCDABCD, we=1; stall holds until rvalid ack.
- lw addr 0x101 → `o_access_fault` pulses once; no `o_mem_req`, no stall.
- gnt delayed 3 cycles, rvalid 2 cycles after grant → `o_stallM` high for 5 cycles; `o_mem_addr`/be/wdata stable throughout REQ.
- Flush in REQ before gnt → req drops next cycle, state IDLE. `i_rst` asserted in RESP → all outputs 0 immediately.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared load/store types for the memory stage.
// funct3 encodings, FSM states, byte-enable type and lane helpers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_e;

  typedef logic [3:0] be_t;

  // sz is funct3[1:0]: 0 byte, 1 half, 2 word
  function automatic be_t be_for(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    be_t be;
    case (sz)
      2'b00:   be = be_t'(4'b0001 << off);
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_for(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks byte/half from a read word and extends it.
// Ports: off_i (addr[1:0]), funct3_i, rdata_i -> data_o (32-bit result).
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{off_i, 3'b000} +: 8];
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'b0, byte_v};
      F3_HU:   data_o = {16'b0, half_v};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// M-stage load/store unit: req/gnt/rvalid bus master with load alignment.
// Ports: M-stage controls in, data bus out/in, ld_dataM, stallM, fault.
module mem_access_stage
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_validM,
  input  logic              i_flushM,
  input  logic              i_mem_rdM,
  input  logic              i_mem_wrM,
  input  logic [2:0]        i_funct3M,
  input  logic [31:0]       i_alu_dataM,
  input  logic [31:0]       i_rs2_dataM,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_ld_dataM,
  output logic              o_stallM,
  output logic              o_access_fault
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  be_t               be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  logic              start;
  logic              misal;
  logic              bad_f3;
  logic              fault;
  logic              issue;
  logic [ADDR_W-1:0] addr_c;
  be_t               be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       ext;

  assign start = i_validM & ~i_flushM
               & (i_mem_rdM | i_mem_wrM);

  always_comb begin
    unique case (i_funct3M)
      F3_H, F3_HU: misal = i_alu_dataM[0];
      F3_W:        misal = |i_alu_dataM[1:0];
      default:     misal = 1'b0;
    endcase
  end

  assign bad_f3 = (i_funct3M[1:0] == 2'b11)
                | (i_funct3M == 3'b110)
                | (i_mem_wrM & i_funct3M[2]);
  assign fault  = misal | bad_f3;
  assign issue  = (state_q == IDLE) & start & ~fault;

  assign addr_c  = {i_alu_dataM[ADDR_W-1:2], 2'b00};
  assign be_c    = be_for(i_funct3M[1:0],
                          i_alu_dataM[1:0]);
  assign wdata_c = i_mem_wrM
                 ? wdata_for(i_funct3M[1:0], i_rs2_dataM)
                 : '0;

  load_extend u_ext (
    .off_i    (off_q),
    .funct3_i (f3_q),
    .rdata_i  (i_mem_rdata),
    .data_o   (ext)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = i_mem_gnt ? RESP : REQ;
      REQ: begin
        // a grant in the flush cycle still wins
        if (i_mem_gnt)     state_d = RESP;
        else if (i_flushM) state_d = IDLE;
      end
      RESP: if (i_mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q  <= addr_c;
        we_q    <= i_mem_wrM;
        be_q    <= be_c;
        wdata_q <= wdata_c;
        f3_q    <= i_funct3M;
        off_q   <= i_alu_dataM[1:0];
      end
    end
  end

  // bus fields are only non-zero while a request is presented
  always_comb begin
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_be       = '0;
    o_mem_wdata    = '0;
    o_ld_dataM     = '0;
    o_stallM       = 1'b0;
    o_access_fault = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        IDLE: begin
          o_access_fault = start & fault;
          if (issue) begin
            o_mem_req   = 1'b1;
            o_mem_we    = i_mem_wrM;
            o_mem_addr  = addr_c;
            o_mem_be    = be_c;
            o_mem_wdata = wdata_c;
            o_stallM    = 1'b1;
          end
        end
        REQ: begin
          o_mem_req   = 1'b1;
          o_mem_we    = we_q;
          o_mem_addr  = addr_q;
          o_mem_be    = be_q;
          o_mem_wdata = wdata_q;
          o_stallM    = 1'b1;
        end
        RESP: begin
          o_stallM = ~i_mem_rvalid;
          if (i_mem_rvalid & ~we_q) o_ld_dataM = ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Random slave latencies, reference model for lanes, faults and loads.
module tb_mem_access_stage;

  logic        clk;
  logic        i_rst;
  logic        i_validM;
  logic        i_flushM;
  logic        i_mem_rdM;
  logic        i_mem_wrM;
  logic [2:0]  i_funct3M;
  logic [31:0] i_alu_dataM;
  logic [31:0] i_rs2_dataM;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_ld_dataM;
  logic        o_stallM;
  logic        o_access_fault;

  mem_access_stage #(.ADDR_W(32)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_validM       (i_validM),
    .i_flushM       (i_flushM),
    .i_mem_rdM      (i_mem_rdM),
    .i_mem_wrM      (i_mem_wrM),
    .i_funct3M      (i_funct3M),
    .i_alu_dataM    (i_alu_dataM),
    .i_rs2_dataM    (i_rs2_dataM),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_be       (o_mem_be),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_gnt      (i_mem_gnt),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata),
    .o_ld_dataM     (o_ld_dataM),
    .o_stallM       (o_stallM),
    .o_access_fault (o_access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          we;
    logic [31:0] rs2;
    bit          has_lit;
    logic [31:0] lit;
    int          slit;
  } exp_t;

  exp_t exp_q[$];
  int   stall_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          gd_next = 0;
  int          rd_next = 0;
  logic [31:0] rdata_next = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit we,
                               input logic [2:0] f3,
                               input logic [31:0] a);
    bit ok;
    if (we) ok = (f3 <= 3'd2);
    else ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (f3[1:0] == 2'b11) ok = 0;
    if (ok && (a % nbytes(f3)) != 0) ok = 0;
    return ok;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int n = nbytes(f3);
    int v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] d);
    int n = nbytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] rd,
                                       input logic [31:0] a,
                                       input logic [2:0] f3);
    int n = nbytes(f3);
    logic [31:0] mask, v;
    logic [63:0] m64;
    m64 = (64'd1 << (n * 8)) - 64'd1;
    mask = m64[31:0];
    v = (rd >> ((a % 4) * 8)) & mask;
    if (!f3[2] && n < 4 && v[n*8-1]) v = v | ~mask;
    return v;
  endfunction

  // bus slave: latencies come from gd_next/rd_next at first request
  initial begin
    int gcnt, rcnt, gd_used;
    bit pend, inreq;
    pend = 0; inreq = 0; gcnt = 0; rcnt = 0; gd_used = 0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
    forever begin
      @(negedge clk);
      i_mem_gnt = 0;
      i_mem_rvalid = 0;
      i_mem_rdata = $urandom;
      if (i_rst) begin
        pend = 0; inreq = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          i_mem_rvalid = 1;
          i_mem_rdata = rdata_next;
          pend = 0;
        end else rcnt--;
      end else if (o_mem_req) begin
        if (!inreq) begin
          inreq = 1; gcnt = gd_next; gd_used = gd_next;
        end
        if (gcnt == 0) begin
          i_mem_gnt = 1;
          inreq = 0;
          pend = 1;
          rcnt = rd_next;
          stall_q.push_back(gd_used + 1 + rd_next);
        end else gcnt--;
      end else begin
        inreq = 0;
        // stray response outside RESP must be ignored
        if ($urandom_range(0, 7) == 0) i_mem_rvalid = 1;
      end
    end
  end

  // monitor
  initial begin
    bit          outst, pr_req;
    exp_t        cur, e;
    int          scnt, sexp;
    logic [31:0] p_addr, p_wd, exp_ld;
    logic [3:0]  p_be;
    logic        p_we;
    outst = 0; pr_req = 0; scnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (i_rst) begin
        outst = 0; pr_req = 0; scnt = 0;
        stall_q.delete();
        continue;
      end
      if (o_access_fault) begin
        if (exp_q.size() == 0 || !exp_q[0].fault) begin
          chk("fault_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("fault_req", o_mem_req, 0);
          chk("fault_stall", o_stallM, 0);
        end
      end
      if (outst) begin
        chk("resp_req", o_mem_req, 0);
        if (i_mem_rvalid) begin
          chk("resp_stall", o_stallM, 0);
          exp_ld = cur.we ? 32'h0
                 : m_ld(i_mem_rdata, cur.addr, cur.f3);
          chk("ld_data", o_ld_dataM, exp_ld);
          if (cur.has_lit) chk("ld_lit", o_ld_dataM, cur.lit);
          if (stall_q.size() == 0) chk("stall_q_empty", 1, 0);
          else begin
            sexp = stall_q.pop_front();
            chk("stall_cycles", scnt, sexp);
          end
          if (cur.slit != 0) chk("stall_lit", scnt, cur.slit);
          outst = 0; scnt = 0;
        end else begin
          chk("resp_wait_stall", o_stallM, 1);
          chk("resp_wait_ld", o_ld_dataM, 0);
          scnt++;
        end
      end else if (o_mem_req) begin
        chk("req_stall", o_stallM, 1);
        scnt++;
        if (pr_req) begin
          chk("hold_addr", o_mem_addr, p_addr);
          chk("hold_be", o_mem_be, p_be);
          chk("hold_we", o_mem_we, p_we);
          chk("hold_wdata", o_mem_wdata, p_wd);
        end
        if (i_mem_gnt) begin
          if (exp_q.size() == 0 || exp_q[0].fault) begin
            chk("req_unexpected", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("req_addr", o_mem_addr, cur.addr & ~32'h3);
            chk("req_we", o_mem_we, cur.we);
            chk("req_be", o_mem_be, m_be(cur.f3, cur.addr));
            if (cur.we)
              chk("req_wdata", o_mem_wdata, m_wd(cur.f3, cur.rs2));
            outst = 1;
          end
        end
      end else begin
        scnt = 0;
        chk("idle_stall", o_stallM, 0);
        chk("idle_ld", o_ld_dataM, 0);
      end
      pr_req = o_mem_req & ~i_mem_gnt;
      p_addr = o_mem_addr;
      p_be = o_mem_be;
      p_we = o_mem_we;
      p_wd = o_mem_wdata;
    end
  end

  task automatic drive(input bit v, input bit fl,
                       input bit rd, input bit wr,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input bit has_lit,
                       input logic [31:0] lit,
                       input int slit);
    exp_t e;
    i_validM = v; i_flushM = fl;
    i_mem_rdM = rd; i_mem_wrM = wr;
    i_funct3M = f3; i_alu_dataM = a; i_rs2_dataM = d;
    if (v && !fl && (rd || wr)) begin
      e.fault = !legal(wr, f3, a);
      e.addr = a; e.f3 = f3; e.we = wr; e.rs2 = d;
      e.has_lit = has_lit; e.lit = lit; e.slit = slit;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input bit v, input bit fl,
                       input bit rd, input bit wr,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input int gd, input int rdl,
                       input logic [31:0] rdat,
                       input bit has_lit,
                       input logic [31:0] lit,
                       input int slit);
    int n;
    @(posedge clk);
    #1;
    gd_next = gd; rd_next = rdl; rdata_next = rdat;
    drive(v, fl, rd, wr, f3, a, d, has_lit, lit, slit);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (o_stallM && n < 100);
    if (n >= 100) chk("stall_timeout", o_stallM, 0);
  endtask

  initial begin
    bit v, fl, rd, wr;
    int k;
    logic [2:0]  f3;
    logic [31:0] a, d;
    i_rst = 1;
    i_validM = 1; i_flushM = 0;
    i_mem_rdM = 1; i_mem_wrM = 0;
    i_funct3M = 3'b010; i_alu_dataM = 32'h100;
    i_rs2_dataM = 32'h1234;
    #3;
    chk("rst_req", o_mem_req, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_be", o_mem_be, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_ld", o_ld_dataM, 0);
    chk("rst_stall", o_stallM, 0);
    chk("rst_fault", o_access_fault, 0);
    @(negedge clk);
    #2;
    i_validM = 0;
    i_rst = 0;

    issue(1, 0, 1, 0, 3'b010, 32'h100, 0, 0, 0,
          32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
    issue(1, 0, 1, 0, 3'b000, 32'h103, 0, 0, 0,
          32'h80112233, 1, 32'hFFFFFF80, 0);
    issue(1, 0, 1, 0, 3'b100, 32'h103, 0, 1, 0,
          32'h80112233, 1, 32'h00000080, 0);
    issue(1, 0, 0, 1, 3'b001, 32'h202, 32'h0000ABCD,
          1, 2, 0, 0, 0, 0);
    issue(1, 0, 1, 0, 3'b010, 32'h101, 0, 0, 0,
          0, 0, 0, 0);
    issue(1, 0, 1, 0, 3'b101, 32'h4F2, 0, 3, 1,
          32'h9ABC1234, 1, 32'h00009ABC, 5);

    // flush while waiting for grant
    @(posedge clk);
    #1;
    gd_next = 10;
    drive(1, 0, 1, 0, 3'b010, 32'h140, 0, 0, 0, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    #2;
    @(posedge clk);
    #1;
    i_flushM = 1;
    @(negedge clk);
    #2;
    chk("flush_cycle_req", o_mem_req, 1);
    @(posedge clk);
    #1;
    i_flushM = 0; i_validM = 0;
    @(negedge clk);
    #2;
    chk("flush_after_req", o_mem_req, 0);
    chk("flush_after_stall", o_stallM, 0);

    // reset while waiting for the response
    @(posedge clk);
    #1;
    gd_next = 0; rd_next = 6;
    drive(1, 0, 1, 0, 3'b010, 32'h180, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    i_rst = 1; i_validM = 0;
    #1;
    chk("rst_resp_req", o_mem_req, 0);
    chk("rst_resp_stall", o_stallM, 0);
    chk("rst_resp_be", o_mem_be, 0);
    chk("rst_resp_ld", o_ld_dataM, 0);
    @(negedge clk);
    #2;
    @(posedge clk);
    #1;
    i_rst = 0;

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      d = $urandom;
      f3 = 3'($urandom_range(0, 7));
      v = 1; fl = 0; rd = 0; wr = 0;
      case (k)
        0: ;
        1: begin v = 0; rd = 1; end
        2: begin fl = 1; wr = 1; end
        default: begin
          if ($urandom_range(0, 1) == 1) rd = 1;
          else wr = 1;
        end
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      issue(v, fl, rd, wr, f3, a, d,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom, 0, 0, 0);
    end

    @(posedge clk);
    #1;
    i_validM = 0;
    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
